// File: rtl/updslow_pkg.sv
// Shared definitions for the slow-path IQ/noise FIFO writer: state encodings
// and the word/lane geometry agreed with the downstream unpacker.
package updslow_pkg;

  localparam int SAMPLE_W            = 16;  // one I, Q or noise sample
  localparam int WORD_W              = 128; // FIFO word width
  localparam int NOISE_PER_WORD      = 8;   // noise samples per FIFO word
  localparam int IQ_BEATS_PER_WORD   = 2;   // RE-pair beats per FIFO word
  localparam int IQ_SAMPLES_PER_BEAT = 4;   // re0_i, re0_q, re1_i, re1_q

  // One-hot user sequencing states
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_FLUSH = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

endpackage : updslow_pkg

// File: rtl/updslow_word_packer.sv
// Generic lane packer: inserts one lane per accepted input starting at the
// LSB lane, writes the full word when the top lane arrives, and on request
// writes a partial word with its unfilled lanes zeroed. Write strobe and data
// are registered (one clock after the completing accept or flush).
module updslow_word_packer
  import updslow_pkg::*;
#(
  parameter int LANE_W = 16,
  parameter int LANES  = 8
) (
  input  logic                      i_core_clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_accept,
  input  logic [LANE_W-1:0]         in_data,
  input  logic                      flush_req,
  input  logic                      fifo_full,
  output logic                      last_lane,
  output logic                      partial,
  output logic                      wen,
  output logic [LANE_W*LANES-1:0]   wdata
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IDX_W-1:0]          idx_reg;
  logic [LANE_W-1:0]         lane_reg [LANES];
  logic [LANE_W*LANES-1:0]   full_word;
  logic [LANE_W*LANES-1:0]   flush_word;
  logic                      do_complete;
  logic                      do_flush;
  logic                      wen_reg;
  logic [LANE_W*LANES-1:0]   wdata_reg;

  assign last_lane   = (idx_reg == IDX_W'(LANES - 1));
  assign partial     = (idx_reg != '0);
  assign do_complete = in_accept && last_lane;
  // A partial word only leaves when the FIFO can take it
  assign do_flush    = flush_req && partial && !fifo_full;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // Completing word: top lane comes straight from the input, the rest from storage
      if (gi == LANES - 1) begin : g_top
        assign full_word[gi*LANE_W +: LANE_W] = in_data;
      end else begin : g_low
        assign full_word[gi*LANE_W +: LANE_W] = lane_reg[gi];
      end
      // Flush word: only lanes below the insert pointer hold data of this user
      assign flush_word[gi*LANE_W +: LANE_W] =
        (IDX_W'(gi) < idx_reg) ? lane_reg[gi] : '0;
    end
  endgenerate

  // Lane storage: the accepted value lands in the slot the insert pointer names
  always_ff @(posedge i_core_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < LANES; i++) lane_reg[i] <= '0;
    end else if (in_accept) begin
      lane_reg[idx_reg] <= in_data;
    end
  end

  // Insert pointer and registered FIFO write port
  always_ff @(posedge i_core_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= '0;
      wen_reg   <= 1'b0;
      wdata_reg <= '0;
    end else begin
      wen_reg <= 1'b0;
      if (clr) begin
        idx_reg <= '0;
      end else if (do_complete) begin
        idx_reg   <= '0;
        wen_reg   <= 1'b1;
        wdata_reg <= full_word;
      end else if (in_accept) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end else if (do_flush) begin
        idx_reg   <= '0;
        wen_reg   <= 1'b1;
        wdata_reg <= flush_word;
      end
    end
  end

  assign wen   = wen_reg;
  assign wdata = wdata_reg;

endmodule : updslow_word_packer

// File: rtl/updslow_iq_noise_fifo_packer.sv
// Writer side of the slow-path IQ/noise FIFO pair. Packs RE-pair beats
// (two per word) and noise samples (eight per word) into 128-bit words,
// sequences one user at a time and flushes partial words at user end.
module updslow_iq_noise_fifo_packer
  import updslow_pkg::*;
#(
  parameter int SAMPLE_W = updslow_pkg::SAMPLE_W,
  parameter int CNT_W    = 16
) (
  input  logic                i_core_clk,
  input  logic                i_rx_rstn,
  input  logic                i_rx_fsm_rstn,
  input  logic                i_user_start,
  input  logic [CNT_W-1:0]    i_cur_user_re_amounts,
  input  logic [CNT_W-1:0]    i_cur_user_noise_amounts,
  input  logic                i_iq_valid,
  input  logic [SAMPLE_W-1:0] i_re0_data_i,
  input  logic [SAMPLE_W-1:0] i_re0_data_q,
  input  logic [SAMPLE_W-1:0] i_re1_data_i,
  input  logic [SAMPLE_W-1:0] i_re1_data_q,
  output logic                o_iq_ready,
  input  logic                i_noise_valid,
  input  logic [SAMPLE_W-1:0] i_noise_data,
  output logic                o_noise_ready,
  input  logic                i_iq_fifo_full,
  input  logic                i_noise_fifo_full,
  output logic                o_iq_fifo_wen,
  output logic [WORD_W-1:0]   o_iq_fifo_wdata,
  output logic                o_noise_fifo_wen,
  output logic [WORD_W-1:0]   o_noise_fifo_wdata,
  output logic                o_user_done,
  output logic                o_busy
);

  localparam int IQ_LANE_W = IQ_SAMPLES_PER_BEAT * SAMPLE_W;
  localparam logic [CNT_W:0] IQ_STEP = (CNT_W + 1)'(2);
  localparam logic [CNT_W:0] NZ_STEP = (CNT_W + 1)'(1);

  logic                  rst_n;
  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      re_amt_reg, nz_amt_reg;
  logic [CNT_W-1:0]      iq_re_cnt_reg, noise_cnt_reg;
  logic [CNT_W:0]        iq_cnt_inc, nz_cnt_inc;
  logic [CNT_W-1:0]      iq_cnt_next, nz_cnt_next;
  logic                  run;
  logic                  start_accept;
  logic                  iq_done, noise_done;
  logic                  iq_accept, nz_accept;
  logic                  iq_last_lane, iq_partial;
  logic                  nz_last_lane, nz_partial;
  logic                  flush_req;
  logic [IQ_LANE_W-1:0]  iq_beat;

  // Either reset source aborts the user immediately
  assign rst_n = i_rx_rstn & i_rx_fsm_rstn;

  assign run          = (state_reg == ST_RUN);
  assign start_accept = (state_reg == ST_IDLE) && i_user_start;
  assign iq_done      = (iq_re_cnt_reg >= re_amt_reg);
  assign noise_done   = (noise_cnt_reg >= nz_amt_reg);

  // The completing lane is held back while its FIFO is full, so a full flag
  // seen at accept time guarantees room for the write one clock later
  assign o_iq_ready    = run && !iq_done    && !(iq_last_lane && i_iq_fifo_full);
  assign o_noise_ready = run && !noise_done && !(nz_last_lane && i_noise_fifo_full);
  assign iq_accept     = i_iq_valid    && o_iq_ready;
  assign nz_accept     = i_noise_valid && o_noise_ready;

  // RE pair in beat order, re0_i at the LSB
  assign iq_beat = {i_re1_data_q, i_re1_data_i, i_re0_data_q, i_re0_data_i};

  // Counters stop at the user's amount so they can never wrap
  assign iq_cnt_inc  = {1'b0, iq_re_cnt_reg} + IQ_STEP;
  assign nz_cnt_inc  = {1'b0, noise_cnt_reg} + NZ_STEP;
  assign iq_cnt_next = (iq_cnt_inc >= {1'b0, re_amt_reg}) ? re_amt_reg : iq_cnt_inc[CNT_W-1:0];
  assign nz_cnt_next = (nz_cnt_inc >= {1'b0, nz_amt_reg}) ? nz_amt_reg : nz_cnt_inc[CNT_W-1:0];

  // Amounts are captured once per user at start
  always_ff @(posedge i_core_clk or negedge rst_n) begin
    if (!rst_n) begin
      re_amt_reg <= '0;
      nz_amt_reg <= '0;
    end else if (start_accept) begin
      re_amt_reg <= i_cur_user_re_amounts;
      nz_amt_reg <= i_cur_user_noise_amounts;
    end
  end

  // RE and noise progress counters, cleared at user start
  always_ff @(posedge i_core_clk or negedge rst_n) begin
    if (!rst_n) begin
      iq_re_cnt_reg <= '0;
      noise_cnt_reg <= '0;
    end else if (start_accept) begin
      iq_re_cnt_reg <= '0;
      noise_cnt_reg <= '0;
    end else begin
      if (iq_accept) iq_re_cnt_reg <= iq_cnt_next;
      if (nz_accept) noise_cnt_reg <= nz_cnt_next;
    end
  end

  // User sequencing state register
  always_ff @(posedge i_core_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_next  = state_reg;
    o_busy      = 1'b0;
    o_user_done = 1'b0;
    flush_req   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (i_user_start) state_next = ST_RUN;
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (iq_done && noise_done) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        o_busy    = 1'b1;
        flush_req = 1'b1;
        // Leave once both partial words have been handed to their FIFOs
        if (!iq_partial && !nz_partial) state_next = ST_DONE;
      end
      ST_DONE: begin
        o_user_done = 1'b1;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  updslow_word_packer #(
    .LANE_W (IQ_LANE_W),
    .LANES  (IQ_BEATS_PER_WORD)
  ) u_iq_packer (
    .i_core_clk (i_core_clk),
    .rst_n      (rst_n),
    .clr        (start_accept),
    .in_accept  (iq_accept),
    .in_data    (iq_beat),
    .flush_req  (flush_req),
    .fifo_full  (i_iq_fifo_full),
    .last_lane  (iq_last_lane),
    .partial    (iq_partial),
    .wen        (o_iq_fifo_wen),
    .wdata      (o_iq_fifo_wdata)
  );

  updslow_word_packer #(
    .LANE_W (SAMPLE_W),
    .LANES  (NOISE_PER_WORD)
  ) u_noise_packer (
    .i_core_clk (i_core_clk),
    .rst_n      (rst_n),
    .clr        (start_accept),
    .in_accept  (nz_accept),
    .in_data    (i_noise_data),
    .flush_req  (flush_req),
    .fifo_full  (i_noise_fifo_full),
    .last_lane  (nz_last_lane),
    .partial    (nz_partial),
    .wen        (o_noise_fifo_wen),
    .wdata      (o_noise_fifo_wdata)
  );

endmodule : updslow_iq_noise_fifo_packer

// File: tb/tb_updslow_iq_noise_fifo_packer.sv
// Bench for the IQ/noise FIFO writer. Expected FIFO words come from a
// word-level model built from the generated beats/samples; ready is
// predicted per cycle from how many beats/samples have been accepted.
`timescale 1ns/1ps
module tb_updslow_iq_noise_fifo_packer;

  logic          i_core_clk = 1'b0;
  logic          i_rx_rstn;
  logic          i_rx_fsm_rstn;
  logic          i_user_start;
  logic [15:0]   i_cur_user_re_amounts;
  logic [15:0]   i_cur_user_noise_amounts;
  logic          i_iq_valid;
  logic [15:0]   i_re0_data_i, i_re0_data_q, i_re1_data_i, i_re1_data_q;
  logic          o_iq_ready;
  logic          i_noise_valid;
  logic [15:0]   i_noise_data;
  logic          o_noise_ready;
  logic          i_iq_fifo_full, i_noise_fifo_full;
  logic          o_iq_fifo_wen, o_noise_fifo_wen;
  logic [127:0]  o_iq_fifo_wdata, o_noise_fifo_wdata;
  logic          o_user_done;
  logic          o_busy;

  updslow_iq_noise_fifo_packer #(.SAMPLE_W(16), .CNT_W(16)) dut (
    .i_core_clk               (i_core_clk),
    .i_rx_rstn                (i_rx_rstn),
    .i_rx_fsm_rstn            (i_rx_fsm_rstn),
    .i_user_start             (i_user_start),
    .i_cur_user_re_amounts    (i_cur_user_re_amounts),
    .i_cur_user_noise_amounts (i_cur_user_noise_amounts),
    .i_iq_valid               (i_iq_valid),
    .i_re0_data_i             (i_re0_data_i),
    .i_re0_data_q             (i_re0_data_q),
    .i_re1_data_i             (i_re1_data_i),
    .i_re1_data_q             (i_re1_data_q),
    .o_iq_ready               (o_iq_ready),
    .i_noise_valid            (i_noise_valid),
    .i_noise_data             (i_noise_data),
    .o_noise_ready            (o_noise_ready),
    .i_iq_fifo_full           (i_iq_fifo_full),
    .i_noise_fifo_full        (i_noise_fifo_full),
    .o_iq_fifo_wen            (o_iq_fifo_wen),
    .o_iq_fifo_wdata          (o_iq_fifo_wdata),
    .o_noise_fifo_wen         (o_noise_fifo_wen),
    .o_noise_fifo_wdata       (o_noise_fifo_wdata),
    .o_user_done              (o_user_done),
    .o_busy                   (o_busy)
  );

  always #5 i_core_clk = ~i_core_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state for the current user
  logic [63:0]  beats[$];
  logic [15:0]  smps[$];
  logic [127:0] exp_iq_q[$], exp_nz_q[$];
  int nb = 0, nn = 0, bi = 0, ni = 0;
  bit run_exp = 1'b0;
  int acc_cyc = 0;

  // Observed traffic
  logic [127:0] obs_iq_q[$], obs_nz_q[$];
  int obs_iq_cyc[$], obs_nz_cyc[$];
  int done_cnt = 0, done_cyc = 0, done_base = 0;

  always @(posedge i_core_clk) cyc <= cyc + 1;

  // Record every FIFO write and done pulse, one line each
  always @(negedge i_core_clk) begin
    if (o_iq_fifo_wen) begin
      obs_iq_q.push_back(o_iq_fifo_wdata);
      obs_iq_cyc.push_back(cyc);
      $display("iq    write cyc=%0d data=%032h", cyc, o_iq_fifo_wdata);
    end
    if (o_noise_fifo_wen) begin
      obs_nz_q.push_back(o_noise_fifo_wdata);
      obs_nz_cyc.push_back(cyc);
      $display("noise write cyc=%0d data=%032h", cyc, o_noise_fifo_wdata);
    end
    if (o_user_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      $display("user  done  cyc=%0d", cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build one user's stimulus and its expected FIFO words, then pulse start
  task automatic prep(input int re, input int nz);
    logic [127:0] w;
    nb = (re + 1) / 2;
    nn = nz;
    bi = 0;
    ni = 0;
    beats.delete(); smps.delete(); exp_iq_q.delete(); exp_nz_q.delete();
    obs_iq_q.delete(); obs_nz_q.delete(); obs_iq_cyc.delete(); obs_nz_cyc.delete();
    for (int k = 0; k < nb; k++) beats.push_back({$urandom, $urandom});
    for (int k = 0; k < nn; k++) smps.push_back(16'($urandom));
    for (int k = 0; k < nb; k += 2) begin
      w = '0;
      w[63:0] = beats[k];
      if (k + 1 < nb) w[127:64] = beats[k+1];
      exp_iq_q.push_back(w);
    end
    for (int k = 0; k < nn; k += 8) begin
      w = '0;
      for (int j = 0; j < 8; j++) if (k + j < nn) w[16*j +: 16] = smps[k+j];
      exp_nz_q.push_back(w);
    end
    done_base = done_cnt;
    i_cur_user_re_amounts    = 16'(re);
    i_cur_user_noise_amounts = 16'(nz);
    i_user_start = 1'b1;
    @(negedge i_core_clk);
    i_user_start = 1'b0;
    run_exp = 1'b1;
    $display("user  start re=%0d noise=%0d", re, nz);
  endtask

  // One clock of stimulus with ready prediction; entered and left at a negedge
  task automatic step(input bit iv, input bit nv, input bit ifull, input bit nfull);
    logic [63:0] b;
    bit exp_ir, exp_nr;
    b = (bi < nb) ? beats[bi] : {$urandom, $urandom};
    i_re0_data_i = b[15:0];
    i_re0_data_q = b[31:16];
    i_re1_data_i = b[47:32];
    i_re1_data_q = b[63:48];
    i_noise_data = (ni < nn) ? smps[ni] : 16'($urandom);
    i_iq_valid = iv;
    i_noise_valid = nv;
    i_iq_fifo_full = ifull;
    i_noise_fifo_full = nfull;
    #1;
    exp_ir = run_exp && (bi < nb) && !((bi % 2 == 1) && ifull);
    exp_nr = run_exp && (ni < nn) && !((ni % 8 == 7) && nfull);
    check("iq_ready", 128'(o_iq_ready), 128'(exp_ir));
    check("noise_ready", 128'(o_noise_ready), 128'(exp_nr));
    acc_cyc = cyc;
    if (iv && exp_ir) bi++;
    if (nv && exp_nr) ni++;
    @(negedge i_core_clk);
  endtask

  // Drive the rest of the user randomly, wait for done, compare all words
  task automatic finish_user(input int vprob, input int fprob);
    int budget;
    int last;
    budget = 0;
    while ((bi < nb || ni < nn) && budget < 3000) begin
      step(int'($urandom_range(99)) < vprob, int'($urandom_range(99)) < vprob,
           int'($urandom_range(99)) < fprob, int'($urandom_range(99)) < fprob);
      budget++;
    end
    check("all_accepted", {64'(bi), 64'(ni)}, {64'(nb), 64'(nn)});
    budget = 0;
    while (done_cnt == done_base && budget < 300) begin
      step(1'b0, 1'b0, int'($urandom_range(99)) < fprob, int'($urandom_range(99)) < fprob);
      budget++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("user_done_pulses", 128'(done_cnt - done_base), 128'(1));
    check("iq_word_count", 128'(obs_iq_q.size()), 128'(exp_iq_q.size()));
    check("noise_word_count", 128'(obs_nz_q.size()), 128'(exp_nz_q.size()));
    for (int k = 0; k < exp_iq_q.size() && k < obs_iq_q.size(); k++)
      check($sformatf("iq_word%0d", k), obs_iq_q[k], exp_iq_q[k]);
    for (int k = 0; k < exp_nz_q.size() && k < obs_nz_q.size(); k++)
      check($sformatf("noise_word%0d", k), obs_nz_q[k], exp_nz_q[k]);
    last = 0;
    if (obs_iq_cyc.size() > 0 && obs_iq_cyc[$] > last) last = obs_iq_cyc[$];
    if (obs_nz_cyc.size() > 0 && obs_nz_cyc[$] > last) last = obs_nz_cyc[$];
    check("done_after_last_write", 128'(done_cyc > last), 128'(1));
    check("busy_after_done", 128'(o_busy), 128'(0));
    run_exp = 1'b0;
  endtask

  initial begin
    int a;
    i_rx_rstn = 1'b0;
    i_rx_fsm_rstn = 1'b1;
    i_user_start = 1'b0;
    i_cur_user_re_amounts = '0;
    i_cur_user_noise_amounts = '0;
    i_iq_valid = 1'b1;
    i_noise_valid = 1'b1;
    i_re0_data_i = 16'h1111; i_re0_data_q = 16'h2222;
    i_re1_data_i = 16'h3333; i_re1_data_q = 16'h4444;
    i_noise_data = 16'h5555;
    i_iq_fifo_full = 1'b0;
    i_noise_fifo_full = 1'b0;

    // Reset state
    repeat (3) @(negedge i_core_clk);
    check("rst_iq_wen", 128'(o_iq_fifo_wen), 128'(0));
    check("rst_nz_wen", 128'(o_noise_fifo_wen), 128'(0));
    check("rst_iq_wdata", o_iq_fifo_wdata, 128'(0));
    check("rst_nz_wdata", o_noise_fifo_wdata, 128'(0));
    check("rst_ready", {126'(0), o_iq_ready, o_noise_ready}, 128'(0));
    check("rst_busy_done", {126'(0), o_busy, o_user_done}, 128'(0));
    i_rx_rstn = 1'b1;
    @(negedge i_core_clk);
    // Offers in IDLE are not accepted
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Full words only: 4 beats, 8 samples
    prep(8, 8);
    check("busy_in_run", 128'(o_busy), 128'(1));
    finish_user(100, 0);
    check("word0_re0_i", 128'((obs_iq_q.size() > 0) ? obs_iq_q[0][15:0] : 16'hxxxx), 128'(beats[0][15:0]));

    // Partial words zero-filled on flush
    prep(6, 3);
    finish_user(100, 0);
    check("iq_w1_upper_zero", (obs_iq_q.size() > 1) ? 128'(obs_iq_q[1][127:64]) : 128'hx, 128'(0));
    check("nz_w0_upper_zero", (obs_nz_q.size() > 0) ? 128'(obs_nz_q[0][127:48]) : 128'hx, 128'(0));

    // Full FIFO holds back the completing beat
    prep(4, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
    check("no_write_while_full", 128'(obs_iq_q.size()), 128'(0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    a = acc_cyc;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("full_release_latency", 128'((obs_iq_cyc.size() > 0) ? obs_iq_cyc[0] : -1), 128'(a + 1));
    check("full_release_data", (obs_iq_q.size() > 0) ? obs_iq_q[0] : 128'hx, exp_iq_q[0]);
    finish_user(100, 0);

    // IQ and noise words completing in the same cycle
    prep(4, 8);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    a = acc_cyc;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("simul_iq_cyc", 128'((obs_iq_cyc.size() > 0) ? obs_iq_cyc[0] : -1), 128'(a + 1));
    check("simul_nz_cyc", 128'((obs_nz_cyc.size() > 0) ? obs_nz_cyc[0] : -1), 128'(a + 1));
    finish_user(100, 0);

    // FSM abort after one beat
    prep(4, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    i_iq_valid = 1'b1;
    i_rx_fsm_rstn = 1'b0;
    #1;
    check("abort_busy", 128'(o_busy), 128'(0));
    check("abort_ready", 128'(o_iq_ready), 128'(0));
    @(negedge i_core_clk);
    i_rx_fsm_rstn = 1'b1;
    run_exp = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("abort_no_iq_write", 128'(obs_iq_q.size()), 128'(0));
    check("abort_no_nz_write", 128'(obs_nz_q.size()), 128'(0));
    prep(2, 1);
    finish_user(100, 0);

    // Start pulse while running is ignored
    prep(6, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    i_user_start = 1'b1;
    i_cur_user_re_amounts = 16'd2;
    i_cur_user_noise_amounts = 16'd1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    i_user_start = 1'b0;
    i_cur_user_re_amounts = 16'd6;
    i_cur_user_noise_amounts = 16'd2;
    check("start_in_run_busy", 128'(o_busy), 128'(1));
    finish_user(100, 0);

    // Random users with random back-pressure
    for (int u = 0; u < 6; u++) begin
      prep(int'($urandom_range(20, 1)), int'($urandom_range(30, 1)));
      finish_user(int'($urandom_range(100, 30)), int'($urandom_range(40, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_updslow_iq_noise_fifo_packer
